// File: rtl/ro_counter_array.sv
// Gated ring-oscillator edge counter array: counts synchronised rising edges per
// channel over a programmable window and exposes the latched results as a byte stream.
module ro_counter_array #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int WIN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ro_in,
    input  logic [WIN_W-1:0]    win_len,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic                shift,
    output logic [7:0]          dout,
    output logic                running,
    output logic                done,
    output logic [CHANNELS-1:0] overflow
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_LATCH} state_t;

    state_t                          r_state, w_next;
    logic [CHANNELS-1:0]             r_sync1, r_sync2, r_sync3;
    logic [CHANNELS-1:0]             w_edge;
    logic [CHANNELS-1:0][CNT_W-1:0]  r_cnt;
    logic [CHANNELS*CNT_W-1:0]       r_result;
    logic [CHANNELS-1:0]             r_ovf;
    logic [WIN_W-1:0]                r_win, r_cyc;
    logic                            r_mode;
    logic                            w_accept, w_win_end, w_clear, w_count_en;

    assign w_edge     = r_sync2 & ~r_sync3;
    assign w_accept   = (r_state == S_IDLE) && start && !stop && (win_len != '0);
    assign w_win_end  = (r_cyc == r_win - 1'b1);
    assign w_count_en = (r_state == S_COUNT) && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next  = S_COUNT;
                    w_clear = 1'b1;
                end
            end
            S_COUNT: begin
                if (stop)           w_next = S_IDLE;
                else if (w_win_end) w_next = S_LATCH;
            end
            S_LATCH: begin
                if (r_mode && !stop) begin
                    w_next  = S_COUNT;
                    w_clear = 1'b1;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_win  <= win_len;
            r_mode <= mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_cyc <= '0;
        else if (w_clear)           r_cyc <= '0;
        else if (r_state == S_COUNT) r_cyc <= r_cyc + 1'b1;
    end

    // Overflow is sticky across continuous restarts; only an accepted start clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            if (w_accept) r_ovf <= '0;
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                if (w_clear) begin
                    r_cnt[ch] <= '0;
                end else if (w_count_en && w_edge[ch]) begin
                    if (r_cnt[ch] == '1) r_ovf[ch] <= 1'b1;
                    else                 r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_result <= '0;
        else if (r_state == S_LATCH) r_result <= r_cnt;
        else if (shift)              r_result <= r_result >> 8;
    end

    assign dout     = r_result[7:0];
    assign running  = (r_state != S_IDLE);
    assign done     = (r_state == S_LATCH);
    assign overflow = r_ovf;

endmodule

// File: tb/tb_ro_counter_array.sv
// Directed bench for ro_counter_array: a 16-bit and an 8-bit counter instance share
// stimulus; expected counts follow from the fixed oscillator periods and window lengths.
module tb_ro_counter_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ro_in = '0;
    logic [15:0] win_len = '0;
    logic        start = 1'b0, stop = 1'b0, mode = 1'b0, shift = 1'b0;

    logic [7:0]  dout16, dout8;
    logic        running16, running8, done16, done8;
    logic [3:0]  ovf16, ovf8;

    int n_chk = 0, n_pass = 0, cyc = 0, n_done = 0, ph = 0;
    bit en0 = 0, en1 = 0, en2 = 0;

    ro_counter_array #(.CHANNELS(4), .CNT_W(16), .WIN_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .win_len(win_len), .start(start),
        .stop(stop), .mode(mode), .shift(shift), .dout(dout16),
        .running(running16), .done(done16), .overflow(ovf16)
    );

    ro_counter_array #(.CHANNELS(4), .CNT_W(8), .WIN_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .ro_in(ro_in), .win_len(win_len), .start(start),
        .stop(stop), .mode(mode), .shift(shift), .dout(dout8),
        .running(running8), .done(done8), .overflow(ovf8)
    );

    always #5 clk = ~clk;

    // Free-running oscillator models: ch0 period 10, ch1 period 4, ch2 period 2.
    always begin
        @(posedge clk);
        #1;
        ph++;
        ro_in[0] = en0 && ((ph % 10) >= 5);
        ro_in[1] = en1 && ((ph % 4) >= 2);
        ro_in[2] = en2 && ((ph % 2) == 1);
        ro_in[3] = 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done16) n_done <= n_done + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_win(input logic [15:0] wl, input logic md);
        win_len = wl;
        mode    = md;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit found);
        found = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done16) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic shift_n(input int n);
        @(posedge clk);
        #1 shift = 1'b1;
        repeat (n) @(posedge clk);
        #1 shift = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  runc, d0;
        int  t[3];
        bit  f;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout16", dout16, 8'h00);
        check("rst_running16", running16, 1'b0);
        check("rst_done16", done16, 1'b0);
        check("rst_ovf8", ovf8, 4'b0000);
        rst = 1'b0;

        // Zero-length window is ignored.
        @(posedge clk);
        #1;
        d0 = n_done;
        win_len = 16'd0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wl0_running", running16, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        check("wl0_no_done", n_done - d0, 0);

        // Single-shot, ch0 period 10 over 100 cycles.
        @(posedge clk);
        #1 en0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        d0 = n_done;
        start_win(16'd100, 1'b0);
        runc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (running16) runc++;
        end
        check("ss_running_cycles", runc, 101);
        check("ss_done_once", n_done - d0, 1);
        check("ss_byte0_16", dout16, 8'h0A);
        check("ss_byte0_8", dout8, 8'h0A);
        check("ss_ovf16", ovf16, 4'b0000);

        // Abort on cycle 20 keeps the previous result.
        @(posedge clk);
        #1;
        d0 = n_done;
        start_win(16'd100, 1'b0);
        repeat (19) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("abort_running", running16, 1'b0);
        repeat (150) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        check("abort_keep16", dout16, 8'h0A);
        check("abort_keep8", dout8, 8'h0A);

        for (int i = 1; i < 8; i++) begin
            shift_n(1);
            check("ss_byte_n16", dout16, 8'h00);
        end
        check("ss_byte_n8", dout8, 8'h00);

        // Continuous mode, ch1 period 4 over 50-cycle windows.
        @(posedge clk);
        #1 en0 = 1'b0;
        repeat (20) @(posedge clk);
        #1 en1 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        d0 = n_done;
        start_win(16'd50, 1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_done(60, f);
            check("cont_done_seen", f, 1'b1);
            t[k] = cyc;
            if (k < 2) begin
                shift_n(2);
                check("cont_ch1_12or13", (dout16 == 8'd12) || (dout16 == 8'd13), 1'b1);
                check("cont_ch2_8", dout8, 8'h00);
            end
        end
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("cont_stop_running", running16, 1'b0);
        check("cont_interval1", t[1] - t[0], 51);
        check("cont_interval2", t[2] - t[1], 51);
        repeat (120) @(negedge clk);
        check("cont_done_total", n_done - d0, 3);
        shift_n(2);
        check("cont_last_ch1", (dout16 == 8'd12) || (dout16 == 8'd13), 1'b1);

        // Saturation on the 8-bit instance, ch2 period 2 over 1000 cycles.
        @(posedge clk);
        #1 en1 = 1'b0;
        repeat (20) @(posedge clk);
        #1 en2 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start_win(16'd1000, 1'b0);
        wait_done(1100, f);
        check("sat_done_seen", f, 1'b1);
        check("sat_ovf8", ovf8, 4'b0100);
        check("sat_ovf16", ovf16, 4'b0000);
        shift_n(2);
        check("sat_ch2_8", dout8, 8'hFF);
        check("sat_ch1_16", dout16, 8'h00);
        shift_n(2);
        check("sat_ch2_lo16", dout16, 8'hF4);
        shift_n(1);
        check("sat_ch2_hi16", dout16, 8'h01);

        // start with stop held is not accepted and leaves overflow alone.
        @(posedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("startstop_running", running16, 1'b0);
        check("startstop_ovf8", ovf8, 4'b0100);

        // Accepted start clears overflow; ch0 over 20 cycles gives 2 edges.
        @(posedge clk);
        #1 en2 = 1'b0;
        en0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start_win(16'd20, 1'b0);
        @(negedge clk);
        check("clr_ovf8", ovf8, 4'b0000);
        check("clr_running", running16, 1'b1);
        wait_done(40, f);
        check("clr_done_seen", f, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("clr_ch0_16", dout16, 8'h02);
        check("clr_ch0_8", dout8, 8'h02);

        // Asynchronous reset mid-window.
        @(posedge clk);
        #1 en0 = 1'b0;
        en2 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        start_win(16'd1000, 1'b0);
        repeat (600) @(posedge clk);
        @(negedge clk);
        check("rstmid_ovf8_pre", ovf8, 4'b0100);
        check("rstmid_running_pre", running8, 1'b1);
        d0 = n_done;
        rst = 1'b1;
        #1;
        check("rstmid_dout16", dout16, 8'h00);
        check("rstmid_dout8", dout8, 8'h00);
        check("rstmid_running", running16, 1'b0);
        check("rstmid_done", done16, 1'b0);
        check("rstmid_ovf8", ovf8, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("rstmid_no_done", n_done - d0, 0);
        check("rstmid_idle", running16, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ro_counter_array.md
RO_COUNTER_ARRAY -- requirements
Module: ro_counter_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent oscillator count channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, per-channel count width, a multiple of 8 (8..32).
REQ-003 SHALL have parameter WIN_W, default 16, gate-window length register width.
REQ-004 SHALL have port clk  input  1  single system clock; all state rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ro_in  input  CHANNELS  asynchronous oscillator-derived signals, one per channel.
REQ-007 SHALL have port win_len  input  WIN_W  gate window length in clk cycles, sampled on accepted start.
REQ-008 SHALL have port start  input  1  begin measurement (level, sampled each cycle).
REQ-009 SHALL have port stop  input  1  abort current window / end continuous mode.
REQ-010 SHALL have port mode  input  1  0 = single-shot, 1 = continuous, sampled on accepted start.
REQ-011 SHALL have port shift  input  1  advance result readout by one byte.
REQ-012 SHALL have port dout  output  8  current readout byte.
REQ-013 SHALL have port running  output  1  high while a window is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a window's results are latched.
REQ-015 SHALL have port overflow  output  CHANNELS  sticky per-channel saturation flags.

Function
REQ-016 Each ro_in bit SHALL pass through a 2-flop synchroniser plus one edge-detect flop; one rising edge is counted per synchronised 0->1 transition (ro_in to count latency 3 cycles).
REQ-017 FSM states SHALL be IDLE, COUNT, LATCH.
REQ-018 IDLE: start=1, stop=0, win_len!=0 -> latch win_len and mode, clear all channel counters, go COUNT next cycle; win_len=0 -> start ignored, remain IDLE, no done.
REQ-019 COUNT SHALL last exactly the latched win_len cycles, counting edges detected in those cycles only; then go LATCH.
REQ-020 Channel counters SHALL saturate at 2^CNT_W-1; an edge arriving at saturation sets that channel's overflow bit.
REQ-021 LATCH (one cycle): copy all counters into a CHANNELS*CNT_W result register, channel 0 in the least significant bits; pulse done for that cycle.
REQ-022 From LATCH: latched mode=1 and stop=0 -> clear counters, re-enter COUNT with the same window; otherwise -> IDLE.
REQ-023 stop=1 in COUNT SHALL abort to IDLE next cycle: no latch, no done, result register unchanged.
REQ-024 start while not IDLE SHALL be ignored; start and stop both high in IDLE -> remain IDLE.
REQ-025 running SHALL be 1 in COUNT and LATCH, 0 in IDLE.
REQ-026 dout SHALL equal result register bits [7:0] combinationally from the register.
REQ-027 shift=1 for one cycle SHALL shift the result register right by 8, zero-filling the top; holding shift high shifts every cycle.
REQ-028 shift in the same cycle as LATCH: latch wins, shift discarded.
REQ-029 overflow bits SHALL clear only on accepted start or reset; continuous-mode restarts do not clear them.
REQ-030 Edges in IDLE or during LATCH SHALL not be counted.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and clear synchronisers, counters, result register, latched win_len/mode and overflow; dout=0, running=0, done=0, overflow=0.
REQ-032 rst asserted mid-COUNT SHALL discard the window with no done pulse; operation resumes only on a new start after rst deasserts.

Verification
REQ-033 CHANNELS=4, CNT_W=16: win_len=100, mode=0, ro_in[0] toggling period 10 clk, others static, start one cycle -> running 100+1 cycles, done pulses once, dout bytes over 8 shifts = 0x0A,0x00 then six 0x00 (±1 count edge tolerance).
REQ-034 mode=1, win_len=50, ro_in[1] period 4 -> done pulses every 51 cycles, each latch ch1 count 12 or 13; stop raised -> running falls after current LATCH, no further done.
REQ-035 stop asserted on cycle 20 of a win_len=100 single-shot -> running low next cycle, no done, dout keeps previous result.
REQ-036 CNT_W=8, ro_in[2] period 2 clk, win_len=1000 -> ch2 result 0xFF, overflow=4'b0100; next accepted start clears overflow.
REQ-037 start with win_len=0 -> stays IDLE, running=0, done never; rst pulse during COUNT -> all outputs 0 within same cycle, no done.
